// File: rtl/counter_pkg.sv
// counter_pkg
// Shared definitions for the dedicated counter processor: datapath defaults
// and the control unit's state encoding, so both ends agree on one copy.
// No ports.
package counter_pkg;

  localparam int WIDTH_DEF      = 8;
  localparam int LIMIT_DEF      = 10;
  localparam int FIFO_DEPTH_DEF = 4;

  // Control unit states: clear A, test ALt10, publish A, increment A, halt.
  typedef enum logic [2:0] {
    ST_CLEAR = 3'd0,
    ST_TEST  = 3'd1,
    ST_OUT   = 3'd2,
    ST_INC   = 3'd3,
    ST_HALT  = 3'd4
  } state_t;

endpackage

// File: rtl/counter_out_fifo.sv
// counter_out_fifo
// Small first-word fall-through FIFO holding the values published by the
// counter datapath until the downstream consumer takes them.
// Ports:
//   clk_i    clock, rising edge
//   rst_ni   synchronous active-low reset (empties the FIFO)
//   push_i   write data_i at the tail (caller guarantees room or a same-cycle pop)
//   data_i   write data
//   pop_i    drop the head entry (caller guarantees valid_o)
//   valid_o  FIFO non-empty
//   data_o   head entry, 0 while empty
//   full_o   all DEPTH entries occupied
module counter_out_fifo
  import counter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; the gated read below hides stale contents.
  // On push+pop while full, wr_ptr equals rd_ptr: the head is consumed this
  // cycle and its slot becomes the new tail, keeping order intact.
  always_ff @(posedge clk_i) begin
    if (rst_ni && push_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign valid_o = (count_q != '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/counter_datapath.sv
// counter_datapath
// Datapath for the dedicated counter processor. Holds register A, clears or
// increments it under control-unit command, reports A < LIMIT, and queues
// every published value into an output FIFO drained over valid/ready.
// Optional feature macro: COUNTER_DP_OVF_CNT_EN adds the ovf_cnt port that
// counts publishes dropped because the FIFO was full (saturating at 255).
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-low reset
//   AsrcSel    A source: 0 -> constant 0, 1 -> A+1
//   ALoad      load enable for A
//   OutBufSel  output buffer enable; rising edge publishes A
//   ALt10      A < LIMIT (combinational)
//   outport    A while OutBufSel=1, else 0 (combinational)
//   out_valid  FIFO non-empty
//   out_ready  consumer accepts head entry
//   out_data   FIFO head (first-word fall-through)
//   ovf_cnt    dropped-publish count (only with COUNTER_DP_OVF_CNT_EN)
module counter_datapath
  import counter_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int LIMIT      = LIMIT_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             AsrcSel,
  input  logic             ALoad,
  input  logic             OutBufSel,
  output logic             ALt10,
  output logic [WIDTH-1:0] outport,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef COUNTER_DP_OVF_CNT_EN
  ,
  output logic [7:0]       ovf_cnt
`endif
);

  localparam logic [WIDTH-1:0] LIMIT_W = WIDTH'(LIMIT);

  logic [WIDTH-1:0] a_q, a_d;
  logic             obs_q;
  logic             pub;
  logic             pop;
  logic             push;
  logic             full;

  always_comb begin
    a_d = a_q;
    if (ALoad) a_d = AsrcSel ? a_q + WIDTH'(1) : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      a_q   <= '0;
      obs_q <= 1'b0;
    end else begin
      a_q   <= a_d;
      obs_q <= OutBufSel;
    end
  end

  assign ALt10   = (a_q < LIMIT_W);
  assign outport = OutBufSel ? a_q : '0;

  // One publish per rising edge of OutBufSel; the halt level pushes once.
  // The pushed value is the registered A, i.e. before any same-cycle load.
  assign pub  = OutBufSel & ~obs_q;
  assign pop  = out_valid & out_ready;
  assign push = pub & (~full | pop);

  counter_out_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (push),
    .data_i  (a_q),
    .pop_i   (pop),
    .valid_o (out_valid),
    .data_o  (out_data),
    .full_o  (full)
  );

`ifdef COUNTER_DP_OVF_CNT_EN
  logic [7:0] ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (pub && full && !pop && (ovf_q != 8'hFF)) ovf_d = ovf_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) ovf_q <= '0;
    else      ovf_q <= ovf_d;
  end

  assign ovf_cnt = ovf_q;
`endif

endmodule

// File: tb/tb_counter_datapath.sv
// tb_counter_datapath
// Directed bench for counter_datapath: reset, full control-unit sequence,
// halt hold, backpressure/overflow, full with simultaneous pop, mid-stream
// reset, and WIDTH=4 wrap on a second instance.
module tb_counter_datapath;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       AsrcSel = 1'b0;
  logic       ALoad = 1'b0;
  logic       OutBufSel = 1'b0;
  logic       out_ready = 1'b0;

  logic       ALt10;
  logic [7:0] outport;
  logic       out_valid;
  logic [7:0] out_data;

  logic       ALt10_w;
  logic [3:0] outport_w;
  logic       out_valid_w;
  logic [3:0] out_data_w;

`ifdef COUNTER_DP_OVF_CNT_EN
  logic [7:0] ovf_cnt;
  logic [7:0] ovf_cnt_w;
`endif

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] got_q[$];

  always #5 clk = ~clk;

  counter_datapath #(.WIDTH(8), .LIMIT(10), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .AsrcSel   (AsrcSel),
    .ALoad     (ALoad),
    .OutBufSel (OutBufSel),
    .ALt10     (ALt10),
    .outport   (outport),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef COUNTER_DP_OVF_CNT_EN
    ,
    .ovf_cnt   (ovf_cnt)
`endif
  );

  counter_datapath #(.WIDTH(4), .LIMIT(10), .FIFO_DEPTH(4)) dut_w (
    .clk       (clk),
    .rst       (rst),
    .AsrcSel   (AsrcSel),
    .ALoad     (ALoad),
    .OutBufSel (OutBufSel),
    .ALt10     (ALt10_w),
    .outport   (outport_w),
    .out_valid (out_valid_w),
    .out_ready (out_ready),
    .out_data  (out_data_w)
`ifdef COUNTER_DP_OVF_CNT_EN
    ,
    .ovf_cnt   (ovf_cnt_w)
`endif
  );

  // Record every value the consumer accepts from the main instance.
  always @(posedge clk) begin
    if (rst && out_valid && out_ready) got_q.push_back(out_data);
  end

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    got_q.delete();
  endtask

  // One publish with a same-cycle increment, then a cycle with OutBufSel low.
  task automatic publish_inc();
    OutBufSel = 1'b1; ALoad = 1'b1; AsrcSel = 1'b1;
    tick();
    OutBufSel = 1'b0; ALoad = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] exp_drain [5];
    exp_drain = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd7};

    // Reset held two cycles with an increment requested.
    rst = 1'b0; ALoad = 1'b1; AsrcSel = 1'b1;
    tick();
    tick();
    check("rst_alt10", ALt10, 1);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_valid_w", out_valid_w, 0);
    check("rst_data_w", out_data_w, 0);
    check("rst_outport_off", outport, 0);
    OutBufSel = 1'b1;
    #1;
    check("rst_outport_a", outport, 0);
`ifdef COUNTER_DP_OVF_CNT_EN
    check("rst_ovf", ovf_cnt, 0);
    check("rst_ovf_w", ovf_cnt_w, 0);
`endif
    OutBufSel = 1'b0; ALoad = 1'b0; AsrcSel = 1'b0;
    rst = 1'b1; out_ready = 1'b1;
    tick();
    check("rst_hold_valid", out_valid, 0);

    // Wrap on the 4-bit instance: 15 + 1 -> 0.
    ALoad = 1'b1; AsrcSel = 1'b0;
    tick();
    AsrcSel = 1'b1;
    repeat (15) tick();
    ALoad = 1'b0;
    #1;
    check("wrap_lt_at15", ALt10_w, 0);
    OutBufSel = 1'b1;
    #1;
    check("wrap_out15", outport_w, 15);
    tick();
    OutBufSel = 1'b0; ALoad = 1'b1;
    tick();
    ALoad = 1'b0;
    #1;
    check("wrap_lt_at0", ALt10_w, 1);
    check("wrap_main16_lt", ALt10, 0);
    OutBufSel = 1'b1;
    #1;
    check("wrap_out0", outport_w, 0);
    OutBufSel = 1'b0;
    tick();

    // Full control-unit sequence with the consumer always ready.
    do_reset();
    out_ready = 1'b1; AsrcSel = 1'b0; ALoad = 1'b1;
    tick();
    ALoad = 1'b0;
    #1;
    for (int i = 0; i <= 10; i++) begin
      check("seq_alt10", ALt10, (i < 10) ? 1 : 0);
      if (i < 10) begin
        OutBufSel = 1'b1; ALoad = 1'b1; AsrcSel = 1'b1;
        #1;
        check("seq_outport", outport, i);
        tick();
        OutBufSel = 1'b0; ALoad = 1'b0;
        tick();
      end
    end
    // Halt: OutBufSel held high for 20 cycles pushes 10 exactly once.
    OutBufSel = 1'b1;
    #1;
    for (int c = 0; c < 20; c++) begin
      check("halt_outport", outport, 10);
      tick();
    end
    OutBufSel = 1'b0;
    tick();
    check("seq_pops", got_q.size(), 11);
    for (int k = 0; k < 11; k++) begin
      if (k < got_q.size()) check("seq_data", got_q[k], k);
    end
    check("seq_empty", out_valid, 0);

    // Backpressure: six publishes of 0..5 into a depth-4 FIFO.
    do_reset();
    out_ready = 1'b0; AsrcSel = 1'b0; ALoad = 1'b1;
    tick();
    ALoad = 1'b0;
    tick();
    OutBufSel = 1'b1; ALoad = 1'b1; AsrcSel = 1'b1;
    #1;
    check("no_bypass", out_valid, 0);
    tick();
    check("push_latency", out_valid, 1);
    check("push_head", out_data, 0);
    OutBufSel = 1'b0; ALoad = 1'b0;
    tick();
    for (int p = 1; p <= 5; p++) publish_inc();
    check("bp_valid", out_valid, 1);
    check("bp_head_stable", out_data, 0);
`ifdef COUNTER_DP_OVF_CNT_EN
    check("bp_ovf", ovf_cnt, 2);
`endif
    // A is 6; step to 7 and publish while popping the full FIFO.
    ALoad = 1'b1;
    tick();
    ALoad = 1'b0; OutBufSel = 1'b1; out_ready = 1'b1;
    tick();
    OutBufSel = 1'b0; out_ready = 1'b0;
    check("fp_pop_cnt", got_q.size(), 1);
    check("fp_new_head", out_data, 1);
    tick();
    // Still full: another publish must be dropped.
    OutBufSel = 1'b1;
    tick();
    OutBufSel = 1'b0;
    tick();
`ifdef COUNTER_DP_OVF_CNT_EN
    check("fp_ovf", ovf_cnt, 3);
`endif
    out_ready = 1'b1;
    repeat (3) tick();
    check("drain_tail_valid", out_valid, 1);
    check("drain_tail", out_data, 7);
    tick();
    check("drain_empty", out_valid, 0);
    out_ready = 1'b0;
    check("drain_cnt", got_q.size(), 5);
    for (int k = 0; k < 5; k++) begin
      if (k < got_q.size()) check("drain_order", got_q[k], exp_drain[k]);
    end

    // Mid-stream reset empties the FIFO with no handshake.
    publish_inc();
    publish_inc();
    check("mid_valid", out_valid, 1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_data", out_data, 0);
    check("mid_rst_alt10", ALt10, 1);
`ifdef COUNTER_DP_OVF_CNT_EN
    check("mid_rst_ovf", ovf_cnt, 0);
`endif
    tick();
    check("mid_rst_stays", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
